// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite bus bundle between a master and the SRAM slave.
interface ahb_sram_slave_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADY;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic                  HREADYOUT;
   logic                  HRESP;
   modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                   input HRDATA, HREADYOUT, HRESP);
   modport slave (input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with lane strobes, wait states and two-cycle ERROR.
// Define AHB_SRAM_PARITY_EN to add per-byte even parity with par_inj error injection.
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0
) (
   input logic HCLK,
   input logic HRESETn,
   ahb_sram_slave_if.slave bus
`ifdef AHB_SRAM_PARITY_EN
   ,
   input logic par_inj
`endif
);
   localparam int AW = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** AW;
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d, strb_q, strb_d, strb;
   logic [AW-1:0]         addr_q, addr_d, idx;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, fwd;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  done, acc, illegal, commit, hit, rd_err;
   logic                  unused_htrans0;

   assign unused_htrans0 = bus.HTRANS[0];
   assign idx = bus.HADDR[ADDR_WIDTH-1:2];
   assign done = state_q == IDLE || state_q == ERR2 || (state_q == DATA && cnt_q == 4'd0);
   assign acc = bus.HSEL & bus.HTRANS[1] & bus.HREADY & done;
   assign commit = state_q == DATA && cnt_q == 4'd0 && write_q;
   assign hit = commit && addr_q == idx;
   assign illegal = (bus.HSIZE > 3'd2) | ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                    ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'd0));
   assign strb = bus.HSIZE == 3'd0 ? 4'b0001 << bus.HADDR[1:0] :
                 bus.HSIZE == 3'd1 ? (bus.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;

   // A write completing at this edge overrides the stale stored bytes of a same-word read.
   always_comb begin
      fwd = mem[idx];
      for (int i = 0; i < 4; i++)
         if (hit && strb_q[i]) fwd[8*i +: 8] = bus.HWDATA[8*i +: 8];
   end

`ifdef AHB_SRAM_PARITY_EN
   logic [3:0] par_mem [DEPTH];
   logic [3:0] par_fwd;
   always_comb begin
      par_fwd = par_mem[idx];
      rd_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (hit && strb_q[i]) par_fwd[i] = ^bus.HWDATA[8*i +: 8] ^ par_inj;
         rd_err = rd_err | (strb[i] & (par_fwd[i] ^ ^fwd[8*i +: 8]));
      end
   end
   always_ff @(posedge HCLK)
      if (commit)
         for (int i = 0; i < 4; i++)
            if (strb_q[i]) par_mem[addr_q][i] <= ^bus.HWDATA[8*i +: 8] ^ par_inj;
`else
   assign rd_err = 1'b0;
`endif

   always_ff @(posedge HCLK)
      if (commit)
         for (int i = 0; i < 4; i++)
            if (strb_q[i]) mem[addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      strb_d  = strb_q;
      write_d = write_q;
      rdata_d = rdata_q;
      if (state_q == ERR1) begin
         state_d = ERR2;
      end else if (state_q == DATA && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         state_d = IDLE;
         rdata_d = '0;
         if (acc) begin
            addr_d  = idx;
            strb_d  = strb;
            write_d = bus.HWRITE;
            if (illegal || (!bus.HWRITE && rd_err)) begin
               state_d = ERR1;
            end else begin
               state_d = DATA;
               cnt_d   = WS;
               rdata_d = bus.HWRITE ? '0 : fwd;
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         strb_q  <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         strb_q  <= strb_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end

   assign bus.HRDATA    = rdata_q;
   assign bus.HREADYOUT = !(state_q == ERR1 || (state_q == DATA && cnt_q != 4'd0));
   assign bus.HRESP     = state_q == ERR1 || state_q == ERR2;
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave SRAM with parametrised depth and a correctly pipelined address/data phase.
- Supports byte, halfword and word writes with lane strobes, and programmable wait states.
- Returns a two-cycle ERROR response for illegal transfers.
- Sits on the system AHB bus as the general-purpose data RAM.

Parameters:
- ADDR_WIDTH, 12, byte-address width; storage is 2^(ADDR_WIDTH-2) words.
- DATA_WIDTH, 32, bus and word width; fixed at 32 in this generation.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in each valid data phase (0..15).

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  AHB reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus ready; qualifies the address phase.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Clock and reset: HCLK clock; HRESETn reset, asynchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, pending write discarded, wait counter=0. Memory contents are not reset.
- Address phase is accepted on a rising edge with HSEL & HTRANS[1] & HREADY. The block registers addr, size, write and the computed 4-bit byte strobe.
- Strobe rules:
  - byte: lane = HADDR[1:0].
  - half: lanes {HADDR[1],0} and {HADDR[1],1}.
  - word: all four lanes.
- Illegal transfer is any of: HSIZE>2; half with HADDR[0]=1; word with HADDR[1:0]!=0.
- IDLE/BUSY transfers, HSEL=0 or HREADY=0: no access; the next data phase is zero-wait OKAY.
- State machine: IDLE, DATA, ERR1, ERR2.
  - IDLE -> DATA on a legal accepted transfer. Wait counter loads WAIT_STATES.
  - IDLE -> ERR1 on an illegal accepted transfer.
  - DATA: HREADYOUT=0 while counter!=0; the counter decrements each cycle. When counter=0, HREADYOUT=1 and the phase completes at that edge.
  - DATA, on completion: -> DATA if a new legal transfer is accepted at the same edge; -> ERR1 if an illegal one is accepted; else -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Completes at that edge and accepts a new address phase as DATA does.
  - No wait states are applied to error responses.
- Write: HWDATA is sampled at the edge where the write data phase completes. Only strobed bytes of the word at addr[ADDR_WIDTH-1:2] are updated. Illegal transfers never write.
- Read:
  - The memory word is captured into HRDATA at the edge accepting the read address phase.
  - HRDATA holds through any wait states and returns to 0 after the phase completes.
  - HRDATA lanes are not masked; the master selects the lanes it needs.
- Read-after-write forwarding: a write phase may complete at the same edge a read to the same word is accepted. In that case HRDATA carries the newly written strobed bytes merged with the old unstrobed bytes.
- Back-to-back NONSEQ/SEQ transfers at WAIT_STATES=0 sustain one transfer per cycle.
- HRESETn asserted mid-phase: outputs go to their reset values immediately, and no write is committed.

Optional Feature:
- Macro: AHB_SRAM_PARITY_EN.
- Enabled:
  - One even-parity bit is stored per byte.
  - Input port par_inj (1 bit) is added. When par_inj=1 at write commit, the stored parity is inverted for the written bytes.
  - A read whose strobed lanes show a parity mismatch gives an ERROR response: ERR1 then ERR2, with HRDATA=0. Mismatch is detected on the captured word, so the transfer returns ERROR instead of entering DATA.
- Disabled: no parity storage, no par_inj port, and reads never return ERROR.

Test Plan:
- WAIT_STATES=0, word write 0xDEADBEEF @0x010, then word read @0x010 -> HRDATA=0xDEADBEEF in the read data phase; HREADYOUT=1, HRESP=0 throughout.
- Byte write 0xAA @0x011 over word 0x00000000, then read @0x010 -> 0x0000AA00. Half write 0x1234 @0x012, then read -> 0x1234AA00.
- Back-to-back write 0x11223344 @0x020 immediately followed by read @0x020 -> HRDATA=0x11223344 via forwarding, with no stall.
- WAIT_STATES=3, read @0x010 -> HREADYOUT low for exactly 3 cycles, then high with HRDATA valid.
- Word access @0x002 or HSIZE=3 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory unchanged on readback.
- Assert HRESETn low during a WAIT_STATES=3 write data phase -> HREADYOUT=1 and HRDATA=0 immediately; readback shows the old contents.
